// File: rtl/mem_dma_pkg.sv
// Shared types and constants for the mem_dma word-copy engine and the 16-bit byte-addressed mem block.
package mem_dma_pkg;

  localparam int MEM_ADDR_W    = 16;
  localparam int MEM_DATA_W    = 16;
  localparam int DMA_ADDR_STEP = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } dma_state_e;

endpackage

// File: rtl/mem_dma.sv
// Word-copy engine driving a big-endian 16-bit memory port: alternating READ/WRITE cycles per word.
// Optional running checksum of copied words when MEM_DMA_CSUM_EN is defined.
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int DATA_W    = MEM_DATA_W,
  parameter int LEN_W     = 16,
  parameter int ADDR_STEP = DMA_ADDR_STEP
) (
  input  logic              clock_i,
  input  logic              reset_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic              mem_wr_en_o,
  output logic [DATA_W-1:0] mem_wdata_o,
`ifdef MEM_DMA_CSUM_EN
  output logic [15:0]       csum_o,
`endif
  input  logic [DATA_W-1:0] mem_rdata_i
);

  dma_state_e        state_q;
  logic [ADDR_W-1:0] src_ptr_q;
  logic [ADDR_W-1:0] dst_ptr_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [DATA_W-1:0] buf_q;
`ifdef MEM_DMA_CSUM_EN
  logic [15:0]       csum_q;
`endif

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= S_IDLE;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      cnt_q     <= '0;
      buf_q     <= '0;
`ifdef MEM_DMA_CSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            src_ptr_q <= src_addr_i;
            dst_ptr_q <= dst_addr_i;
            cnt_q     <= len_i;
`ifdef MEM_DMA_CSUM_EN
            csum_q    <= '0;
`endif
            state_q   <= (len_i == '0) ? S_DONE : S_READ;
          end
        end
        S_READ: begin
          buf_q     <= mem_rdata_i;
          src_ptr_q <= src_ptr_q + ADDR_W'(ADDR_STEP);
          state_q   <= S_WRITE;
        end
        S_WRITE: begin
          // Memory latches buf_q on this same edge; pointers wrap silently.
          dst_ptr_q <= dst_ptr_q + ADDR_W'(ADDR_STEP);
          cnt_q     <= cnt_q - LEN_W'(1);
`ifdef MEM_DMA_CSUM_EN
          csum_q    <= csum_q + 16'(buf_q);
`endif
          state_q   <= (cnt_q == LEN_W'(1)) ? S_DONE : S_READ;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Strobes decode only from the state register, so async reset kills a pending write at once.
  assign busy_o      = (state_q == S_READ) || (state_q == S_WRITE);
  assign done_o      = (state_q == S_DONE);
  assign mem_wr_en_o = (state_q == S_WRITE);
  assign mem_wdata_o = buf_q;

  always_comb begin
    mem_address_o = '0;
    case (state_q)
      S_READ:  mem_address_o = src_ptr_q;
      S_WRITE: mem_address_o = dst_ptr_q;
      default: mem_address_o = '0;
    endcase
  end

`ifdef MEM_DMA_CSUM_EN
  assign csum_o = csum_q;
`endif

endmodule

// File: doc/mem_dma.md
Name: mem_dma

Overview:
- Word-copy engine: the initiator side of the team's byte-addressed, big-endian 16-bit memory port (combinational read, posedge write of two bytes at address/address+1).
- Given a start pulse, copies LEN 16-bit words from SRC to DST by driving the memory's address / wr_en / data_in and sampling its data_out.
- Sits between the core/testbench control logic and the mem instance, replacing hand-driven memory stimulus.

Parameters:
- ADDR_W, 16, width of memory byte address and of src/dst pointers
- DATA_W, 16, memory word width; must equal 2 bytes (fixed at 16)
- LEN_W, 16, width of word-count input
- ADDR_STEP, 2, byte increment per word

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  request pulse; sampled only in IDLE
- src_addr  in  ADDR_W  source byte address, captured on accepted start
- dst_addr  in  ADDR_W  destination byte address, captured on accepted start
- len  in  LEN_W  number of words to copy, captured on accepted start
- busy  out  1  high while in READ or WRITE
- done  out  1  one-cycle completion pulse
- mem_address  out  ADDR_W  to memory address
- mem_wr_en  out  1  to memory wr_en
- mem_wdata  out  DATA_W  to memory data_in
- mem_rdata  in  DATA_W  from memory data_out (combinational read)

Behaviour:
- States: IDLE, READ, WRITE, DONE. State register reset to IDLE asynchronously when reset=0.
- Reset values: busy=0, done=0, mem_wr_en=0, mem_address=0, mem_wdata=0, all pointers/count/buffer 0.
- IDLE: mem_wr_en=0, mem_address=0. On posedge with start=1: capture src_ptr=src_addr, dst_ptr=dst_addr, cnt=len.
  - len=0 -> DONE.
  - Otherwise -> READ.
- READ: mem_address=src_ptr, mem_wr_en=0. On posedge: buf<=mem_rdata, src_ptr+=ADDR_STEP -> WRITE.
- WRITE: mem_address=dst_ptr, mem_wr_en=1, mem_wdata=buf. On posedge the memory stores buf; dst_ptr+=ADDR_STEP, cnt-=1.
  - If cnt was 1 -> DONE.
  - Otherwise -> READ.
- DONE: done=1 for exactly one cycle, busy=0 -> IDLE.
- Latency: N words = 2N cycles busy after the start edge, then 1 done cycle. A new start is accepted on the cycle after DONE at the earliest.
- mem_wr_en, busy and done decode from the state register only; no combinational path from start.
- Pointer arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- Overlap: strict forward word-by-word copy. A destination overlapping ahead of the source propagates copied data; this is specified behaviour, not an error.
- start while busy or in DONE is ignored; inputs src/dst/len are don't-care outside IDLE.
- Reset mid-operation: mem_wr_en drops immediately (async). No partial-word write is issued after reset asserts. Memory contents already written are kept.
- Odd src/dst addresses are legal; the byte-granular memory handles them.

Optional Feature:
- Macro MEM_DMA_CSUM_EN.
- Defined: extra output csum (16 bits). Cleared on accepted start; on each WRITE posedge, csum<=csum+buf mod 2^16. Holds its value after done until the next accepted start. Reset value 0.
- Undefined: port and adder absent; behaviour otherwise identical.

Decomposition:
- Package mem_dma_pkg:
  - state encoding (IDLE=0, READ=1, WRITE=2, DONE=3)
  - ADDR_STEP constant
  - shared width constants (address 16, word 16) reused by the mem block.
- No sub-module needed; a single FSM with datapath registers. The checksum accumulator stays inline under the macro.

Test Plan:
- Preload mem bytes 0x00..0x05 = 11 22 33 44 55 66; start src=0 dst=0x100 len=3 -> bytes 0x100..0x105 = 11 22 33 44 55 66; busy high 6 cycles; done pulse on cycle 7; with CSUM_EN, csum=0x1122+0x3344+0x5566=0x99CC.
- len=0, src=0 dst=0x10 -> no mem_wr_en assertion; done pulses on the cycle after the start edge; busy never high.
- Overlap: mem 0x00..0x03 = AA BB CC DD; src=0 dst=2 len=2 -> 0x02..0x05 = AA BB AA BB (forward propagation).
- Start pulses at 2 and 4 cycles after an accepted start (src=0x20 len=4) -> ignored; exactly 4 writes, one done.
- Assert reset low mid-WRITE of a len=4 copy -> mem_wr_en=0 and busy=0 in the same timestep; after release, state IDLE and no further writes.
- Wrap: src=0xFFFE dst=0x40 len=2 -> second read at address 0x0000 (pointer wraps), writes at 0x40 and 0x42.
